// File: rtl/mem_stage_dm.sv
`default_nettype none
// mem_stage_dm: MEM-stage data memory with post-reset clear walk and first-bad-access capture.
// Revision 1.0 - initial release
module mem_stage_dm #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] RT_M,
  output logic [31:0] DMout_M,
  output logic        busy,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic [31:0] err_pc,
  output logic [7:0]  err_cnt
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [5:0]    op;
  logic          is_load;
  logic          is_store;
  logic          sz_half;
  logic          sz_word;
  logic          in_range;
  logic          misalign;
  logic          bad;
  logic          run;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          unused_ir;
  assign unused_ir = ^IR_M[25:0];

  assign op   = IR_M[31:26];
  assign run  = (state == RUN);
  assign widx = ALUout_M[AW+1:2];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (op)
      OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LB, OP_LBU: begin is_load  = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SB:         begin is_store = 1'b1; end
      default:       ;
    endcase
  end

  assign in_range = (ALUout_M[31:AW+2] == '0);
  assign misalign = (sz_word && (ALUout_M[1:0] != 2'b00)) || (sz_half && ALUout_M[0]);
  assign bad      = (is_load || is_store) && (misalign || !in_range);

  // The clear walk owns the write port until RUN; stores are ignored meanwhile.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = widx;
    wr_be   = 4'h0;
    wr_data = 32'h0;
    if (!run) begin
      wr_en  = 1'b1;
      wr_idx = clr_cnt;
      wr_be  = 4'hF;
    end else if (is_store && !bad) begin
      wr_en = 1'b1;
      if (sz_word) begin
        wr_be   = 4'hF;
        wr_data = RT_M;
      end else if (sz_half) begin
        wr_be   = ALUout_M[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{RT_M[15:0]}};
      end else begin
        wr_be   = 4'b0001 << ALUout_M[1:0];
        wr_data = {4{RT_M[7:0]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rword = mem[widx];
  assign rbyte = rword[8*ALUout_M[1:0] +: 8];
  assign rhalf = ALUout_M[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    DMout_M = 32'h0;
    if (run && is_load && !bad) begin
      case (op)
        OP_LW:   DMout_M = rword;
        OP_LH:   DMout_M = {{16{rhalf[15]}}, rhalf};
        OP_LHU:  DMout_M = {16'h0, rhalf};
        OP_LB:   DMout_M = {{24{rbyte[7]}}, rbyte};
        OP_LBU:  DMout_M = {24'h0, rbyte};
        default: DMout_M = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      busy      <= 1'b1;
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      err_pc    <= 32'h0;
      err_cnt   <= 8'h0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (bad) begin
            if (!err_valid) begin
              err_valid <= 1'b1;
              err_addr  <= ALUout_M;
              err_pc    <= PC4_M - 32'd4;
            end
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dm.sv
`default_nettype none
// tb_mem_stage_dm: vector table, directed corner sequences and random traffic against a word-array model.
module tb_mem_stage_dm;

  localparam int DW = 16;
  localparam logic [5:0] LW  = 6'b100011, LH  = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011, SH  = 6'b101001, SB  = 6'b101000;
  localparam logic [5:0] NOP = 6'b000000, ODD = 6'b001101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir, pc4, addr, rt;
  logic [31:0] dmout, err_addr, err_pc;
  logic        busy, err_valid;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  mem_stage_dm #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .reset_n(reset_n), .IR_M(ir), .PC4_M(pc4), .ALUout_M(addr), .RT_M(rt),
    .DMout_M(dmout), .busy(busy), .err_valid(err_valid), .err_addr(err_addr),
    .err_pc(err_pc), .err_cnt(err_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_mem [DW];
  logic        m_ev;
  logic [31:0] m_ea, m_ep;
  int          m_cnt;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int opsize(input logic [5:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    return 1;
  endfunction

  function automatic bit is_ld(input logic [5:0] op);
    return (op == LW || op == LH || op == LHU || op == LB || op == LBU);
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return (op == SW || op == SH || op == SB);
  endfunction

  function automatic bit m_bad(input logic [5:0] op, input logic [31:0] a);
    if (!(is_ld(op) || is_st(op))) return 1'b0;
    return (a >= 32'(4 * DW)) || ((a % 32'(opsize(op))) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (!is_ld(op) || m_bad(op, a)) return 32'h0;
    w = m_mem[int'(a / 4)];
    b = 8'(w >> (8 * (a % 4)));
    h = 16'(w >> (16 * ((a / 2) % 2)));
    case (op)
      LW:      return w;
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int          i;
    int          sh;
    logic [31:0] w;
    i = int'(a / 4);
    w = m_mem[i];
    if (op == SW) w = d;
    else if (op == SH) begin
      sh = 16 * int'((a / 2) % 2);
      w  = (w & ~(32'hFFFF << sh)) | ({16'h0, d[15:0]} << sh);
    end else begin
      sh = 8 * int'(a % 4);
      w  = (w & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
    end
    m_mem[i] = w;
  endtask

  // One pipeline cycle: drive, sample the combinational load mid-cycle, commit on the edge.
  task automatic access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, output logic [31:0] dm);
    ir   = {op, 26'($urandom())};
    addr = a;
    rt   = d;
    pc4  = p;
    @(negedge clk);
    dm = dmout;
    chk("dmout_model", dm, m_load(op, a));
    @(posedge clk);
    #1;
    if (m_bad(op, a)) begin
      if (!m_ev) begin
        m_ev = 1'b1;
        m_ea = a;
        m_ep = p - 32'd4;
      end
      if (m_cnt < 255) m_cnt++;
    end else if (is_st(op)) begin
      m_store(op, a, d);
    end
    chk("err_cnt_model", {24'h0, err_cnt}, 32'(m_cnt));
    chk("err_valid_model", {31'h0, err_valid}, {31'h0, m_ev});
  endtask

  task automatic count_walk();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 100);
    chk("busy_edges", 32'(n), 32'(DW));
  endtask

  // Asynchronous reset between edges, reset-value checks, then the full clear walk.
  task automatic do_reset(input bit restart_mid_walk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_err_valid", {31'h0, err_valid}, 32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_pc", err_pc, 32'h0);
    ir   = {LW, 26'h0};
    addr = 32'h14;
    #1;
    chk("rst_dmout", dmout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("walk_dmout", dmout, 32'h0);
    if (restart_mid_walk) begin
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midwalk_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      reset_n = 1'b1;
    end
    count_walk();
    for (int i = 0; i < DW; i++) m_mem[i] = 32'h0;
    m_ev  = 1'b0;
    m_ea  = 32'h0;
    m_ep  = 32'h0;
    m_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    logic [31:0] dm;
    logic [5:0]  ops [10];

    reset_n = 1'b0;
    ir = 32'h0; addr = 32'h0; rt = 32'h0; pc4 = 32'h0;
    #1;
    for (int i = 0; i < DW; i++) dut.mem[i] = 32'hA5A5_0000 | 32'(i);

    do_reset(1'b0);

    for (int a = 0; a < 4 * DW; a += 4) begin
      access(LW, 32'(a), 32'h0, 32'h1000, dm);
      chk("clear_lw", dm, 32'h0);
    end

    tbl[0] = '{SW,  32'h8, 32'h11223344, 32'h0};
    tbl[1] = '{SB,  32'h9, 32'h000000AA, 32'h0};
    tbl[2] = '{SH,  32'hA, 32'h0000BEEF, 32'h0};
    tbl[3] = '{LW,  32'h8, 32'h0,        32'hBEEFAA44};
    tbl[4] = '{SW,  32'h4, 32'h80FF7F01, 32'h0};
    tbl[5] = '{LB,  32'h6, 32'h0,        32'hFFFFFFFF};
    tbl[6] = '{LBU, 32'h6, 32'h0,        32'h000000FF};
    tbl[7] = '{LH,  32'h6, 32'h0,        32'hFFFF80FF};
    tbl[8] = '{LHU, 32'h4, 32'h0,        32'h00007F01};
    tbl[9] = '{LB,  32'h4, 32'h0,        32'h00000001};
    for (int i = 0; i < 10; i++) begin
      access(tbl[i].op, tbl[i].a, tbl[i].d, 32'h2000 + 32'(4 * i), dm);
      chk($sformatf("tbl%0d", i), dm, tbl[i].exp);
    end

    access(LW, 32'h2, 32'h0, 32'h3008, dm);
    chk("bad_lw_zero", dm, 32'h0);
    access(SH, 32'h41, 32'h0000FFFF, 32'h300C, dm);
    access(SW, 32'h40, 32'hDEADBEEF, 32'h3010, dm);
    chk("bad_err_valid", {31'h0, err_valid}, 32'h1);
    chk("bad_err_addr", err_addr, 32'h2);
    chk("bad_err_pc", err_pc, 32'h3004);
    chk("bad_err_cnt", {24'h0, err_cnt}, 32'd3);
    access(LW, 32'h0, 32'h0, 32'h3014, dm);
    chk("bad_mem_w0", dm, 32'h0);
    access(LW, 32'h8, 32'h0, 32'h3018, dm);
    chk("bad_mem_w2", dm, 32'hBEEFAA44);

    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, NOP, ODD};
    for (int i = 0; i < 300; i++) begin
      access(ops[$urandom_range(0, 9)], 32'($urandom_range(0, 4 * DW + 11)),
             $urandom(), $urandom(), dm);
    end
    chk("rand_err_addr", err_addr, m_ea);
    chk("rand_err_pc", err_pc, m_ep);

    do_reset(1'b1);
    access(LW, 32'h8, 32'h0, 32'h4000, dm);
    chk("after_reset_lw", dm, 32'h0);

    for (int i = 0; i < 300; i++) access(LW, 32'h1, 32'h0, 32'h5000 + 32'(4 * i), dm);
    chk("sat_err_cnt", {24'h0, err_cnt}, 32'd255);
    chk("sat_err_addr", err_addr, 32'h1);
    chk("sat_err_pc", err_pc, 32'h4FFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
